// File: rtl/riscv_core_alu_pkg.sv
// Shared definitions for the integer ALU and the two-port arbiter in front of it.
// Control codes, requester ids and the request bundle routed to the ALU.
package riscv_core_alu_pkg;

  localparam int unsigned AluXlen = 64;
  localparam int unsigned AluTagW = 4;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1111;

  localparam logic ReqExe = 1'b0;
  localparam logic ReqAmo = 1'b1;

  typedef struct packed {
    logic [AluXlen-1:0] src_a;
    logic [AluXlen-1:0] src_b;
    logic [3:0]         ctrl;
    logic               is_word;
    logic [AluTagW-1:0] tag;
  } alu_req_t;

  // Codes that have a defined 32-bit (word) form.
  function automatic logic is_word_legal(input logic [3:0] ctrl);
    return (ctrl == AluAdd) || (ctrl == AluSub) || (ctrl == AluSll) ||
           (ctrl == AluSrl) || (ctrl == AluSra);
  endfunction

endpackage

// File: rtl/riscv_core_alu.sv
// Combinational integer ALU; word ops produce a 32-bit result sign-extended to XLEN.
module riscv_core_alu
  import riscv_core_alu_pkg::*;
#(
  parameter int unsigned XLEN = AluXlen
) (
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [3:0]      ctrl_i,
  input  logic            is_word_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] full_res;
  logic [31:0]     word_res;

  assign shamt = src_b_i[4:0];

  always_comb begin
    full_res = '0;
    case (ctrl_i)
      AluAdd:  full_res = src_a_i + src_b_i;
      AluSub:  full_res = src_a_i - src_b_i;
      AluAnd:  full_res = src_a_i & src_b_i;
      AluOr:   full_res = src_a_i | src_b_i;
      AluSll:  full_res = src_a_i << shamt;
      AluSlt:  full_res = {{(XLEN-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
      AluXor:  full_res = src_a_i ^ src_b_i;
      AluSrl:  full_res = src_a_i >> shamt;
      AluSltu: full_res = {{(XLEN-1){1'b0}}, src_a_i < src_b_i};
      AluSra:  full_res = $signed(src_a_i) >>> shamt;
      default: full_res = '0;
    endcase
  end

  // Add/sub low halves match the full-width result; only the shifts need a 32-bit path.
  always_comb begin
    word_res = full_res[31:0];
    case (ctrl_i)
      AluSll:  word_res = src_a_i[31:0] << shamt;
      AluSrl:  word_res = src_a_i[31:0] >> shamt;
      AluSra:  word_res = $signed(src_a_i[31:0]) >>> shamt;
      default: word_res = full_res[31:0];
    endcase
  end

  always_comb begin
    if (is_word_i && is_word_legal(ctrl_i)) begin
      result_o = {{(XLEN-32){word_res[31]}}, word_res};
    end else begin
      result_o = full_res;
    end
  end

endmodule

// File: rtl/riscv_core_rr_arb2.sv
// Two-way round-robin arbiter with a lock override that pins the grant on port 1.
module riscv_core_rr_arb2
  import riscv_core_alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  output logic [1:0] gnt_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o = 2'b00;
    if (rst_i) begin
      gnt_o = 2'b00;
    end else if (lock_i) begin
      gnt_o = {req_i[1], 1'b0};
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_gnt_q == ReqAmo) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (|gnt_o) begin
      last_gnt_d = gnt_o[1];
    end
  end

  // Reset to ReqAmo so the execute stage wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt_q <= ReqAmo;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/riscv_core_alu_arbiter.sv
// Shares one integer ALU between the execute stage (port 0) and the AMO unit (port 1).
// Round-robin arbitration, optional port-1 lock with timeout, registered tagged result.
module riscv_core_alu_arbiter
  import riscv_core_alu_pkg::*;
#(
  parameter int unsigned XLEN     = AluXlen,
  parameter int unsigned TAGW     = AluTagW,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_srcA,
  input  logic [XLEN-1:0] i_req0_srcB,
  input  logic [3:0]      i_req0_ctrl,
  input  logic            i_req0_isword,
  input  logic [TAGW-1:0] i_req0_tag,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_srcA,
  input  logic [XLEN-1:0] i_req1_srcB,
  input  logic [3:0]      i_req1_ctrl,
  input  logic            i_req1_isword,
  input  logic [TAGW-1:0] i_req1_tag,
  input  logic            i_req1_lock,

  output logic            o_rsp0_valid,
  output logic            o_rsp1_valid,
  output logic [XLEN-1:0] o_rsp_result,
  output logic [TAGW-1:0] o_rsp_tag,
  output logic            o_locked,
  output logic            o_lock_err
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  alu_req_t        req0, req1, req_sel;
  logic [1:0]      gnt;
  logic [XLEN-1:0] alu_result;
  logic            lock_timeout;

  logic            lock_q, lock_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_err_q, lock_err_d;
  logic            rsp0_valid_q, rsp1_valid_q;
  logic [XLEN-1:0] result_q;
  logic [TAGW-1:0] tag_q;

  always_comb begin
    req0.src_a   = i_req0_srcA;
    req0.src_b   = i_req0_srcB;
    req0.ctrl    = i_req0_ctrl;
    req0.is_word = i_req0_isword;
    req0.tag     = i_req0_tag;
    req1.src_a   = i_req1_srcA;
    req1.src_b   = i_req1_srcB;
    req1.ctrl    = i_req1_ctrl;
    req1.is_word = i_req1_isword;
    req1.tag     = i_req1_tag;
  end

  // With no grant the ALU sees port 0; its result is discarded.
  assign req_sel = gnt[ReqAmo] ? req1 : req0;

  riscv_core_rr_arb2 u_arb (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .req_i  ({i_req1_valid, i_req0_valid}),
    .lock_i (lock_q),
    .gnt_o  (gnt)
  );

  riscv_core_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .src_a_i   (req_sel.src_a),
    .src_b_i   (req_sel.src_b),
    .ctrl_i    (req_sel.ctrl),
    .is_word_i (req_sel.is_word),
    .result_o  (alu_result)
  );

  assign o_req0_ready = gnt[ReqExe];
  assign o_req1_ready = gnt[ReqAmo];

  assign lock_timeout = lock_q && !gnt[ReqAmo] && (lock_cnt_q == CntW'(LOCK_MAX - 1));

  always_comb begin
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = 1'b0;
    if (gnt[ReqAmo]) begin
      lock_d     = i_req1_lock;
      lock_cnt_d = '0;
    end else if (lock_timeout) begin
      lock_d     = 1'b0;
      lock_cnt_d = '0;
      lock_err_d = 1'b1;
    end else if (lock_q) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      result_q     <= '0;
      tag_q        <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_err_q   <= lock_err_d;
      rsp0_valid_q <= gnt[ReqExe];
      rsp1_valid_q <= gnt[ReqAmo];
      if (|gnt) begin
        result_q <= alu_result;
        tag_q    <= req_sel.tag;
      end
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_tag    = tag_q;
  assign o_locked     = lock_q;
  assign o_lock_err   = lock_err_q;

endmodule

// File: tb/tb_riscv_core_alu_arbiter.sv
// Scoreboard bench: a behavioural model predicts grants and responses, a monitor checks them.
module tb_riscv_core_alu_arbiter;

  localparam int unsigned LOCK_MAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, w0, v1, w1, l1;
  logic [63:0] a0, b0, a1, b1;
  logic [3:0]  c0, t0, c1, t1;

  logic        rdy0, rdy1, rsp0, rsp1, locked, lock_err;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;

  riscv_core_alu_arbiter #(
    .XLEN     (64),
    .TAGW     (4),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req0_valid  (v0),
    .o_req0_ready  (rdy0),
    .i_req0_srcA   (a0),
    .i_req0_srcB   (b0),
    .i_req0_ctrl   (c0),
    .i_req0_isword (w0),
    .i_req0_tag    (t0),
    .i_req1_valid  (v1),
    .o_req1_ready  (rdy1),
    .i_req1_srcA   (a1),
    .i_req1_srcB   (b1),
    .i_req1_ctrl   (c1),
    .i_req1_isword (w1),
    .i_req1_tag    (t1),
    .i_req1_lock   (l1),
    .o_rsp0_valid  (rsp0),
    .o_rsp1_valid  (rsp1),
    .o_rsp_result  (rsp_result),
    .o_rsp_tag     (rsp_tag),
    .o_locked      (locked),
    .o_lock_err    (lock_err)
  );

  // kind: 0/1 = response on that port, 2 = reset values expected
  typedef struct {
    int          due;
    int          kind;
    logic [63:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, want);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] c, input logic w);
    int unsigned sh;
    int          sa, sb, r;
    logic [31:0] u;
    sh = b[4:0];
    if (w) begin
      sa = a[31:0];
      sb = b[31:0];
      u  = a[31:0];
      case (c)
        4'd0:    r = sa + sb;
        4'd1:    r = sa - sb;
        4'd4:    r = sa << sh;
        4'd7:    r = u >> sh;
        4'd15:   r = sa >>> sh;
        default: r = 0;
      endcase
      return {{32{r[31]}}, r};
    end
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd6:    return a ^ b;
      4'd7:    return a >> sh;
      4'd8:    return (a < b) ? 64'd1 : 64'd0;
      4'd15:   return $signed(a) >>> sh;
      default: return 64'd0;
    endcase
  endfunction

  // Reference arbiter state: who won last, lock held, idle cycles spent locked.
  int m_last = 1;
  bit m_locked = 0;
  int m_idle = 0;
  bit m_err = 0;
  bit m_known = 0;

  task automatic model_step();
    bit   e0, e1;
    exp_t e;
    e0 = 0;
    e1 = 0;
    if (!rst) begin
      if (m_locked) e1 = v1;
      else if (v0 && v1) begin
        if (m_last == 1) e0 = 1;
        else e1 = 1;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    check("req0_ready", rdy0, e0);
    check("req1_ready", rdy1, e1);
    if (m_known) begin
      check("locked", locked, m_locked);
      check("lock_err", lock_err, m_err);
    end
    e.due = cyc + 1;
    if (rst) begin
      m_last = 1; m_locked = 0; m_idle = 0; m_err = 0; m_known = 1;
      e.kind = 2; e.res = '0; e.tag = '0;
      exp_q.push_back(e);
    end else begin
      m_err = 0;
      if (e1) begin
        e.kind = 1; e.res = ref_alu(a1, b1, c1, w1); e.tag = t1;
        exp_q.push_back(e);
        m_last = 1; m_locked = l1; m_idle = 0;
      end else begin
        if (e0) begin
          e.kind = 0; e.res = ref_alu(a0, b0, c0, w0); e.tag = t0;
          exp_q.push_back(e);
          m_last = 0;
        end
        if (m_locked) begin
          if (m_idle == LOCK_MAX - 1) begin
            m_locked = 0; m_idle = 0; m_err = 1;
          end else m_idle++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  exp_t        mon_e;
  logic [63:0] last_res;
  logic [3:0]  last_tag;
  bit          hold_known = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      check("rsp0_valid", rsp0, (mon_e.kind == 0));
      check("rsp1_valid", rsp1, (mon_e.kind == 1));
      check("rsp_result", rsp_result, mon_e.res);
      check("rsp_tag", rsp_tag, mon_e.tag);
      last_res   = mon_e.res;
      last_tag   = mon_e.tag;
      hold_known = 1;
    end else if (hold_known) begin
      check("rsp0_idle", rsp0, 0);
      check("rsp1_idle", rsp1, 0);
      check("result_hold", rsp_result, last_res);
      check("tag_hold", rsp_tag, last_tag);
    end
  end

  logic [3:0] ops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd15};
  logic [3:0] wops[5] = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd15};

  task automatic rand_req(output logic [63:0] a, output logic [63:0] b,
                          output logic [3:0] c, output logic w, output logic [3:0] t);
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    w = ($urandom_range(0, 3) == 0);
    c = w ? wops[$urandom_range(0, 4)] : ops[$urandom_range(0, 9)];
    t = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int rate;
    rst = 1; v0 = 0; v1 = 0; l1 = 0; w0 = 0; w1 = 0;
    a0 = '0; b0 = '0; c0 = '0; t0 = '0; a1 = '0; b1 = '0; c1 = '0; t1 = '0;
    tick(); tick();
    rst = 0;

    // Port 0 alone: 5 + 7
    v0 = 1; a0 = 64'd5; b0 = 64'd7; c0 = 4'd0; t0 = 4'd3;
    tick();
    v0 = 0;
    tick();

    // Contention straight after reset alternates 0,1,0,1
    rst = 1; tick(); rst = 0;
    v0 = 1; a0 = 64'd10; b0 = 64'd3; c0 = 4'd1; t0 = 4'd1;
    v1 = 1; a1 = 64'hF0; b1 = 64'h3C; c1 = 4'd2; t1 = 4'd2;
    repeat (4) tick();

    // Word add overflow sign-extends
    v0 = 0; v1 = 1; w1 = 1; c1 = 4'd0; a1 = 64'h7FFF_FFFF; b1 = 64'd1; t1 = 4'd9;
    tick();
    v1 = 0; w1 = 0;
    tick();

    // Lock hold with port 0 waiting, renewed once, then released
    v0 = 1; c0 = 4'd0; v1 = 1; l1 = 1; c1 = 4'd6;
    tick();
    v1 = 0; l1 = 0; repeat (3) tick();
    v1 = 1; l1 = 1; tick();
    v1 = 0; repeat (2) tick();
    v1 = 1; l1 = 0; tick();
    v1 = 0; repeat (2) tick();
    v0 = 0; tick();

    // Lock timeout with port 0 pending
    v0 = 1; v1 = 1; l1 = 1;
    tick();
    v1 = 0; l1 = 0;
    repeat (LOCK_MAX + 3) tick();
    v0 = 0; tick();

    // Reset right after a locked acceptance
    v0 = 1; v1 = 1; l1 = 1; tick();
    tick();
    rst = 1; v1 = 0; l1 = 0; tick();
    rst = 0; v1 = 1; tick();
    v0 = 0; v1 = 0; repeat (2) tick();

    // Randomised traffic in blocks with varying port-1 density
    for (int blk = 0; blk < 8; blk++) begin
      rate = $urandom_range(0, 9);
      for (int i = 0; i < 50; i++) begin
        rand_req(a0, b0, c0, w0, t0);
        rand_req(a1, b1, c1, w1, t1);
        v0  = ($urandom_range(0, 3) != 0);
        v1  = ($urandom_range(0, 9) < rate);
        l1  = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 149) == 0);
        tick();
      end
    end

    rst = 0; v0 = 0; v1 = 0; l1 = 0;
    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_alu_arbiter.md
Name: riscv_core_alu_arbiter

Overview:
Shares the single integer ALU between two requesters.
- Port 0: execute stage (ALU instructions).
- Port 1: atomic-memory-operation unit (AMO read-modify-write).

The block arbitrates each cycle with round-robin, drives the ALU from the winner, and registers the result with a tag. Port 1 may lock the ALU across a multi-beat AMO sequence. It sits between the issue logic/AMO unit and the ALU instance.

Parameters:
- XLEN, 64, operand/result width.
- TAGW, 4, width of the requester tag returned with each result.
- LOCK_MAX, 16, maximum cycles a lock may hold the ALU without a port-1 acceptance before forced release.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_req0_valid  in  1  port-0 request valid.
- o_req0_ready  out  1  port-0 accepted this cycle.
- i_req0_srcA, i_req0_srcB  in  XLEN  port-0 operands.
- i_req0_ctrl  in  4  port-0 ALU control code.
- i_req0_isword  in  1  port-0 32-bit op.
- i_req0_tag  in  TAGW  port-0 tag.
- i_req1_valid / o_req1_ready / i_req1_srcA / i_req1_srcB / i_req1_ctrl / i_req1_isword / i_req1_tag  as port 0, for port 1.
- i_req1_lock  in  1  keep grant on port 1 after this acceptance.
- o_rsp0_valid  out  1  result for port 0 (one-cycle pulse).
- o_rsp1_valid  out  1  result for port 1 (one-cycle pulse).
- o_rsp_result  out  XLEN  registered ALU result.
- o_rsp_tag  out  TAGW  tag of the accepted request.
- o_locked  out  1  lock currently held.
- o_lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
Clock and reset:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: o_rsp0_valid=0, o_rsp1_valid=0, o_rsp_result=0, o_rsp_tag=0, o_locked=0, o_lock_err=0, rr pointer last_gnt=1 (port 0 wins first contention), lock counter=0.
- While i_rst=1, both readys are 0.

Handshake:
- Accept on valid && ready.
- At most one acceptance per cycle; readys are mutually exclusive.
- ready is combinational from the valids, the lock and the rr pointer.
- ready does not depend on the requester's own ready; valid must not depend on ready.

Arbitration, unlocked:
- Only one valid: grant it.
- Both valid: grant the port not equal to last_gnt.
- last_gnt updates only on an acceptance.
- Neither valid: no grant, pointer held.

Lock:
- Port-1 acceptance with i_req1_lock=1 sets lock_q the next cycle.
- While lock_q=1: o_req0_ready=0 and o_req1_ready=i_req1_valid.
- Port-1 acceptance with i_req1_lock=0 clears lock_q.
- Lock counter: reset to 0 on each port-1 acceptance; increments each locked cycle with no port-1 acceptance.
- When the counter reaches LOCK_MAX-1 and there is no acceptance: clear lock_q, pulse o_lock_err, and restore normal arbitration the next cycle.
- o_locked = lock_q.

Datapath:
- ALU inputs are muxed combinationally from the granted port; when there is no grant they are port 0's fields (result ignored).
- Latency is exactly 1 cycle: the cycle after acceptance, o_rspN_valid=1 for the granted N, o_rsp_result = ALU result, o_rsp_tag = that tag.
- With no acceptance, both rsp valids are 0; result/tag hold their last value.
- No response backpressure; consumers must sink every pulse.

ALU semantics (must match the ALU):
- isword=1: 32-bit result sign-extended to XLEN.
- Shifts use srcB[4:0].
- Word ops are legal only for ctrl 0000, 0001, 0100, 0111, 1111.
- Illegal codes produce an undefined result; the arbiter does not check them.

Reset mid-operation: a pending response is dropped (valids 0 the next cycle) and any lock is cleared without o_lock_err.

Decomposition:
- Package riscv_core_alu_pkg:
  - ALU control localparams: ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SLT=0101, XOR=0110, SRL=0111, SLTU=1000, SRA=1111.
  - Requester ids REQ_EXE=0, REQ_AMO=1.
  - Request struct {srcA, srcB, ctrl, isword, tag}.
- Sub-module riscv_core_rr_arb2: 2-way round-robin with lock input; outputs a one-hot grant.
- The existing ALU is instantiated once inside this block.

Test Plan:
1. Port 0 only: srcA=5, srcB=7, ctrl=0000 -> ready same cycle; next cycle rsp0_valid=1, result=12, tag echoed; rsp1_valid=0.
2. Both valid every cycle after reset: port 0 ctrl=0001 srcA=10 srcB=3; port 1 ctrl=0010 srcA=0xF0 srcB=0x3C -> grants alternate 0,1,0,1; results alternate 7 and 0x30.
3. Word op: port 1, isword=1, ctrl=0000, srcA=0x7FFFFFFF, srcB=1 -> result 0xFFFFFFFF80000000.
4. Lock hold: port 1 accepted with lock=1, port 0 valid throughout -> o_locked=1, req0_ready=0 until port 1 accepts with lock=0; port 0 is granted the following cycle.
5. Lock timeout: lock taken, then port 1 idles LOCK_MAX=16 cycles -> o_lock_err pulses once, o_locked=0, pending port-0 request granted the next cycle.
6. Reset mid-operation: assert i_rst in the cycle after an acceptance while locked -> rsp valids 0, o_locked=0, o_lock_err=0; first post-reset contention grants port 0.
